hazard_stall_ctrl: RTL

- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Decides each cycle whether PC and the F/D register hold, whether D/E receives a bubble, and whether F/D, D/E and E/M are flushed.
- Owns the multiply/divide busy countdown, so md-dependent instructions in D wait until HI/LO is ready.
- Its hold output drives the stopen inputs of the PC and F/D pipeline registers; its clear output drives D/E.

---
 rtl/pipe_defs.sv | 28 ++
 rtl/md_busy_cnt.sv | 63 ++++++
 rtl/hazard_stall_ctrl.sv | 73 +++++++
 3 files changed

// File: rtl/pipe_defs.sv
// Shared pipeline definitions: Tuse/Tnew encodings, md latency defaults, hazard match helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipe_defs;

    // Tuse/Tnew are 2-bit cycle counts. A Tuse of 3 means the operand is never read.
    typedef logic [1:0] tcnt_t;

    localparam tcnt_t TUSE_NONE = 2'd3;
    localparam tcnt_t TNEW_E_MAX = 2'd2;
    localparam tcnt_t TNEW_M_MAX = 2'd1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A D-stage source must wait when a later stage will write it too late.
    // $0 is hardwired, and an unused operand never waits.
    function automatic logic hz_match(input logic [4:0] src, input logic [4:0] dst,
                                      input tcnt_t tuse, input tcnt_t tnew);
        return (src != 5'd0) && (src == dst) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Multiply/divide busy countdown: loads a fixed latency when an md op issues from E.
// Latency: busy rises the cycle after start and stays high for exactly MULT/DIV cycles.
// Backpressure: none; a start while busy is ignored, a killed start never loads.
module md_busy_cnt
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic kill,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and count registers; reset aborts any count in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a flushed start never loads, an issued op always runs to completion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MD_IDLE: begin
                if (start && !kill) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = is_div ? DIV_LD : MULT_LD;
                end
            end
            MD_BUSY: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = MD_IDLE;
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: holds PC and F/D, bubbles D/E, flushes on exceptions.
// Latency: stall and flush are combinational in the cycle the hazard or exception appears.
// Backpressure: stall holds PC/F-D and injects a D/E bubble; flush overrides stall; reset forces all outputs low.
module hazard_stall_ctrl
    import pipe_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic       md_use_D,
    input  logic [4:0] a3_E,
    input  logic [1:0] tnew_E,
    input  logic [4:0] a3_M,
    input  logic [1:0] tnew_M,
    input  logic       md_start_E,
    input  logic       md_is_div_E,
    input  logic       exc_req_M,
    output logic       hold_pc,
    output logic       hold_fd,
    output logic       clr_de,
    output logic       flush,
    output logic       md_busy
);

    logic busy_raw;
    logic match_any;
    logic md_stall;
    logic stall;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_is_div_E),
        .kill   (exc_req_M),
        .busy   (busy_raw)
    );

    // Register-dependency stall: either D source waiting on an E or M producer.
    always_comb begin
        match_any = hz_match(rs_D, a3_E, tuse_rs_D, tnew_E)
                  | hz_match(rt_D, a3_E, tuse_rt_D, tnew_E)
                  | hz_match(rs_D, a3_M, tuse_rs_D, tnew_M)
                  | hz_match(rt_D, a3_M, tuse_rt_D, tnew_M);
    end

    // HI/LO consumers wait while the md unit is counting or just issuing.
    always_comb begin
        md_stall = md_use_D & (busy_raw | md_start_E);
        stall    = match_any | md_stall;
    end

    // Flush wins over stall; reset silences every output.
    always_comb begin
        flush   = exc_req_M & ~reset;
        hold_pc = stall & ~exc_req_M & ~reset;
        hold_fd = hold_pc;
        clr_de  = hold_pc;
        md_busy = busy_raw & ~reset;
    end

endmodule
